// File: rtl/noise_channel_pkg.sv
// Shared sound package: divisor table, output step derivation, LFSR defaults
// and envelope/length field widths used by the noise and pulse channels.
package noise_channel_pkg;

    localparam int unsigned LFSR_W_DEF    = 15;
    localparam int unsigned SHORT_TAP_DEF = 6;

    localparam int unsigned VOL_W      = 4;
    localparam int unsigned ENV_PER_W  = 3;
    localparam int unsigned LEN_LOAD_W = 6;
    localparam int unsigned LEN_CNT_W  = 7;   // holds 1..64

    localparam logic [VOL_W-1:0] VOL_MAX = '1;

    // Frequency divisor for codes 0..7.
    function automatic logic [6:0] divisor(input logic [2:0] code);
        logic [6:0] d;
        case (code)
            3'd0:    d = 7'd8;
            3'd1:    d = 7'd16;
            3'd2:    d = 7'd32;
            3'd3:    d = 7'd48;
            3'd4:    d = 7'd64;
            3'd5:    d = 7'd80;
            3'd6:    d = 7'd96;
            3'd7:    d = 7'd112;
            default: d = 7'd8;
        endcase
        return d;
    endfunction

    // Per-volume-step magnitude: ((2^(W-1) - 1) / 15) >> 2.
    function automatic int unsigned calc_step(input int unsigned sample_w);
        longint unsigned full;
        full = (64'd1 << (sample_w - 1)) - 64'd1;
        return 32'((full / 64'd15) >> 2);
    endfunction

endpackage

// File: rtl/sound_envelope.sv
// Volume envelope: step timer plus saturating 4-bit volume counter.
// Ports: i_clk, i_rst_n (async active-low), i_tick (pre-qualified envelope
// strobe), i_trigger (reload), i_init, i_dir (1 = up), i_period (0 = frozen),
// o_volume.
module sound_envelope
    import noise_channel_pkg::*;
(
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_tick,
    input  logic                 i_trigger,
    input  logic [VOL_W-1:0]     i_init,
    input  logic                 i_dir,
    input  logic [ENV_PER_W-1:0] i_period,
    output logic [VOL_W-1:0]     o_volume
);

    logic [ENV_PER_W-1:0] r_cnt;
    logic [VOL_W-1:0]     r_volume;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt    <= '0;
            r_volume <= '0;
        end else if (i_trigger) begin
            r_cnt    <= i_period;
            r_volume <= i_init;
        end else if (i_tick && (i_period != '0)) begin
            // A count of 0 (loaded while frozen) expires like 1.
            if (r_cnt <= ENV_PER_W'(1)) begin
                r_cnt <= i_period;
                if (i_dir && (r_volume != VOL_MAX))
                    r_volume <= r_volume + VOL_W'(1);
                else if (!i_dir && (r_volume != '0))
                    r_volume <= r_volume - VOL_W'(1);
            end else begin
                r_cnt <= r_cnt - ENV_PER_W'(1);
            end
        end
    end

    assign o_volume = r_volume;

endmodule

// File: rtl/noise_channel.sv
// Noise voice (channel 4): LFSR with 15/7-bit feedback, programmable
// frequency divider, volume envelope and length counter, producing a signed
// sample on each mixer strobe.
// Inputs: clock/reset, timer/length/envelope/sample strobes, trigger and the
// register-file fields. Outputs: O_SAMPLE (signed), O_ACTIVE (enabled).
module noise_channel
    import noise_channel_pkg::*;
#(
    parameter int unsigned SAMPLE_W  = 20,
    parameter int unsigned LFSR_W    = LFSR_W_DEF,
    parameter int unsigned SHORT_TAP = SHORT_TAP_DEF,
    parameter int unsigned DIV_W     = 20
) (
    input  logic                  I_BITCLK,
    input  logic                  I_RESET_N,
    input  logic                  I_TIMER_TICK,
    input  logic                  I_LEN_TICK,
    input  logic                  I_ENV_TICK,
    input  logic                  I_STROBE,
    input  logic                  I_TRIGGER,
    input  logic [2:0]            I_DIV_CODE,
    input  logic [3:0]            I_SHIFT,
    input  logic                  I_WIDTH_MODE,
    input  logic [3:0]            I_ENV_INIT,
    input  logic                  I_ENV_DIR,
    input  logic [2:0]            I_ENV_PERIOD,
    input  logic [5:0]            I_LEN_LOAD,
    input  logic                  I_LEN_EN,
    output logic [SAMPLE_W-1:0]   O_SAMPLE,
    output logic                  O_ACTIVE
);

    localparam logic [SAMPLE_W-1:0] STEP       = SAMPLE_W'(calc_step(SAMPLE_W));
    localparam logic [3:0]          SHIFT_HOLD = 4'd14;

    logic [LFSR_W-1:0]    r_lfsr;
    logic [DIV_W-1:0]     r_freq_cnt;
    logic [LEN_CNT_W-1:0] r_len_cnt;
    logic                 r_active;
    logic [SAMPLE_W-1:0]  r_sample;

    logic                 w_dac_on;
    logic                 w_trig;
    logic                 w_run;
    logic                 w_fb;
    logic [LFSR_W-1:0]    w_lfsr_next;
    logic [DIV_W-1:0]     w_period;
    logic                 w_freq_step;
    logic                 w_len_step;
    logic [VOL_W-1:0]     w_volume;
    logic [SAMPLE_W-1:0]  w_mag;

    assign w_dac_on = (I_ENV_INIT != 4'd0) || I_ENV_DIR;
    assign w_trig   = I_TRIGGER && w_dac_on;
    // Ticks only act on a running channel with no trigger or DAC-off pending.
    assign w_run    = r_active && w_dac_on && !I_TRIGGER;

    assign w_period    = DIV_W'(divisor(I_DIV_CODE)) << I_SHIFT;
    assign w_freq_step = w_run && I_TIMER_TICK && (I_SHIFT < SHIFT_HOLD);
    assign w_len_step  = w_run && I_LEN_TICK && I_LEN_EN;

    assign w_fb = r_lfsr[0] ^ r_lfsr[1];
    always_comb begin
        w_lfsr_next = {w_fb, r_lfsr[LFSR_W-1:1]};
        if (I_WIDTH_MODE)
            w_lfsr_next[SHORT_TAP] = w_fb;
    end

    sound_envelope u_env (
        .i_clk     (I_BITCLK),
        .i_rst_n   (I_RESET_N),
        .i_tick    (I_ENV_TICK && w_run),
        .i_trigger (w_trig),
        .i_init    (I_ENV_INIT),
        .i_dir     (I_ENV_DIR),
        .i_period  (I_ENV_PERIOD),
        .o_volume  (w_volume)
    );

    assign w_mag = STEP * SAMPLE_W'(w_volume);

    always_ff @(posedge I_BITCLK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            r_lfsr     <= '1;
            r_freq_cnt <= '0;
            r_len_cnt  <= '0;
            r_active   <= 1'b0;
            r_sample   <= '0;
        end else begin
            // Sample is taken from pre-edge state regardless of other updates.
            if (I_STROBE)
                r_sample <= !r_active ? '0 : (r_lfsr[0] ? w_mag : -w_mag);

            if (w_trig) begin
                r_active   <= 1'b1;
                r_lfsr     <= '1;
                r_freq_cnt <= w_period;
                r_len_cnt  <= LEN_CNT_W'(64) - LEN_CNT_W'(I_LEN_LOAD);
            end else if (!w_dac_on) begin
                r_active <= 1'b0;
            end else begin
                if (w_freq_step) begin
                    if (r_freq_cnt <= DIV_W'(1)) begin
                        r_freq_cnt <= w_period;
                        r_lfsr     <= w_lfsr_next;
                    end else begin
                        r_freq_cnt <= r_freq_cnt - DIV_W'(1);
                    end
                end
                if (w_len_step) begin
                    if (r_len_cnt <= LEN_CNT_W'(1)) begin
                        r_len_cnt <= '0;
                        r_active  <= 1'b0;
                    end else begin
                        r_len_cnt <= r_len_cnt - LEN_CNT_W'(1);
                    end
                end
            end
        end
    end

    assign O_SAMPLE = r_sample;
    assign O_ACTIVE = r_active;

endmodule

// File: tb/tb_noise_channel.sv
module tb_noise_channel;

    localparam int STEP = 8738;
    localparam int FULL = 131070;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        timer = 1'b0, len_tick = 1'b0, env_tick = 1'b0, strobe = 1'b0, trigger = 1'b0;
    logic [2:0]  code = '0;
    logic [3:0]  shift = '0;
    logic        mode = 1'b0;
    logic [3:0]  env_init = '0;
    logic        env_dir = 1'b0;
    logic [2:0]  env_period = '0;
    logic [5:0]  len_load = '0;
    logic        len_en = 1'b0;
    logic [19:0] sample;
    logic        active;

    int n_vec = 0;
    int n_bad = 0;
    bit use_model = 1'b0;

    int m_active, m_lfsr, m_vol, m_envc, m_freq, m_len, m_sample;

    typedef struct {
        int init; int dir; int code; int shift; int ticks;
        int exp_sample; int exp_active;
    } vec_t;
    vec_t tbl[12];

    always #5 clk = ~clk;

    noise_channel dut (
        .I_BITCLK     (clk),
        .I_RESET_N    (rst_n),
        .I_TIMER_TICK (timer),
        .I_LEN_TICK   (len_tick),
        .I_ENV_TICK   (env_tick),
        .I_STROBE     (strobe),
        .I_TRIGGER    (trigger),
        .I_DIV_CODE   (code),
        .I_SHIFT      (shift),
        .I_WIDTH_MODE (mode),
        .I_ENV_INIT   (env_init),
        .I_ENV_DIR    (env_dir),
        .I_ENV_PERIOD (env_period),
        .I_LEN_LOAD   (len_load),
        .I_LEN_EN     (len_en),
        .O_SAMPLE     (sample),
        .O_ACTIVE     (active)
    );

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int s_out();
        return int'($signed(sample));
    endfunction

    function automatic int lfsr_adv(input int l, input bit short_m);
        int fb;
        fb = (l ^ (l >> 1)) & 1;
        l = (l >> 1) | (fb << 14);
        if (short_m) l = (l & ~(1 << 6)) | (fb << 6);
        return l;
    endfunction

    function automatic int clamp15(input int v);
        return (v > 15) ? 15 : ((v < 0) ? 0 : v);
    endfunction

    task automatic model_reset();
        m_active = 0; m_lfsr = 32'h7FFF; m_vol = 0;
        m_envc = 0; m_freq = 0; m_len = 0; m_sample = 0;
    endtask

    // Reference: one edge of channel behaviour from the register-level rules.
    task automatic model_edge();
        bit dac;
        dac = (env_init != 0) || env_dir;
        if (strobe)
            m_sample = (m_active == 0) ? 0 : ((m_lfsr & 1) ? m_vol * STEP : -(m_vol * STEP));
        if (trigger && dac) begin
            m_active = 1; m_lfsr = 32'h7FFF; m_vol = int'(env_init);
            m_envc = int'(env_period);
            m_freq = ((code == 0) ? 8 : 16 * int'(code)) << shift;
            m_len = 64 - int'(len_load);
        end else if (!dac) begin
            m_active = 0;
        end else if (m_active != 0) begin
            if (timer && shift < 14) begin
                m_freq = m_freq - 1;
                if (m_freq <= 0) begin
                    m_freq = ((code == 0) ? 8 : 16 * int'(code)) << shift;
                    m_lfsr = lfsr_adv(m_lfsr, mode);
                end
            end
            if (env_tick && env_period != 0) begin
                m_envc = m_envc - 1;
                if (m_envc <= 0) begin
                    m_envc = int'(env_period);
                    m_vol = clamp15(m_vol + (env_dir ? 1 : -1));
                end
            end
            if (len_tick && len_en) begin
                m_len = m_len - 1;
                if (m_len <= 0) begin m_len = 0; m_active = 0; end
            end
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (use_model) model_edge();
        #1;
        trigger = 0; timer = 0; env_tick = 0; len_tick = 0; strobe = 0;
    endtask

    task automatic timer_ticks(input int n);
        for (int i = 0; i < n; i++) begin timer = 1; cyc(); end
    endtask

    task automatic config_ch(input int init, input int dir, input int per,
                             input int c, input int sh);
        env_init = 4'(init); env_dir = dir[0]; env_period = 3'(per);
        code = 3'(c); shift = 4'(sh);
    endtask

    task automatic do_strobe();
        strobe = 1; cyc();
    endtask

    int seq[254];
    int mism, ones, k;

    initial begin
        tbl[0]  = '{15, 0, 0, 0,    0,  FULL, 1};
        tbl[1]  = '{15, 0, 0, 0,    8,  FULL, 1};
        tbl[2]  = '{15, 0, 0, 0,  112,  FULL, 1};
        tbl[3]  = '{15, 0, 0, 0,  120, -FULL, 1};
        tbl[4]  = '{15, 0, 1, 0,  239,  FULL, 1};
        tbl[5]  = '{15, 0, 1, 0,  240, -FULL, 1};
        tbl[6]  = '{ 1, 0, 0, 1,  240, -STEP, 1};
        tbl[7]  = '{ 7, 0, 7, 0, 1679,  7 * STEP, 1};
        tbl[8]  = '{ 7, 0, 7, 0, 1680, -7 * STEP, 1};
        tbl[9]  = '{ 3, 0, 0, 14, 200,  3 * STEP, 1};
        tbl[10] = '{ 0, 1, 2, 2,    0,  0, 1};
        tbl[11] = '{ 0, 0, 3, 0,    0,  0, 0};

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("reset_sample", s_out(), 0);
        check("reset_active", int'(active), 0);
        rst_n = 1;
        do_strobe();
        check("idle_sample", s_out(), 0);
        check("idle_active", int'(active), 0);

        // Table: trigger, N timer ticks, strobe
        for (int i = 0; i < 12; i++) begin
            config_ch(tbl[i].init, tbl[i].dir, 0, tbl[i].code, tbl[i].shift);
            mode = 0; len_en = 0;
            trigger = 1; cyc();
            timer_ticks(tbl[i].ticks);
            do_strobe();
            check($sformatf("tbl%0d_sample", i), s_out(), tbl[i].exp_sample);
            check($sformatf("tbl%0d_active", i), int'(active), tbl[i].exp_active);
        end

        // Envelope decrement to zero, then saturation
        config_ch(2, 0, 1, 0, 14);
        trigger = 1; cyc();
        do_strobe(); check("env_v2", s_out(), 2 * STEP);
        env_tick = 1; cyc(); do_strobe(); check("env_v1", s_out(), STEP);
        env_tick = 1; cyc(); do_strobe(); check("env_v0", s_out(), 0);
        env_tick = 1; cyc(); do_strobe(); check("env_floor", s_out(), 0);
        check("env_active", int'(active), 1);
        config_ch(14, 1, 1, 0, 14);
        trigger = 1; cyc();
        repeat (3) begin env_tick = 1; cyc(); end
        do_strobe(); check("env_ceiling", s_out(), FULL);

        // Length expiry coinciding with a strobe
        config_ch(15, 0, 0, 0, 14);
        len_load = 62; len_en = 1;
        trigger = 1; cyc();
        len_tick = 1; cyc();
        check("len_after1", int'(active), 1);
        len_tick = 1; strobe = 1; cyc();
        check("len_expiry_sample", s_out(), FULL);
        check("len_expired", int'(active), 0);
        do_strobe(); check("len_dead_sample", s_out(), 0);
        trigger = 1; cyc();
        check("len_retrigger", int'(active), 1);
        do_strobe(); check("len_retrig_sample", s_out(), FULL);
        len_en = 0;

        // Trigger colliding with envelope tick and timer expiry
        config_ch(15, 0, 1, 0, 0);
        trigger = 1; cyc();
        timer_ticks(127);
        env_tick = 1; cyc();
        do_strobe(); check("coll_pre", s_out(), -14 * STEP);
        trigger = 1; env_tick = 1; timer = 1; cyc();
        do_strobe(); check("coll_post", s_out(), FULL);
        timer_ticks(119);
        do_strobe(); check("coll_period_119", s_out(), FULL);
        timer_ticks(1);
        do_strobe(); check("coll_period_120", s_out(), -FULL);

        // DAC switched off mid-run
        config_ch(5, 0, 0, 0, 0);
        trigger = 1; cyc();
        env_init = 0; timer = 1; cyc();
        check("dac_off_active", int'(active), 0);

        // Short mode: b0 sequence repeats every 127 shifts
        config_ch(15, 0, 0, 0, 0);
        mode = 1;
        trigger = 1; cyc();
        for (int i = 0; i < 254; i++) begin
            timer_ticks(8);
            do_strobe();
            seq[i] = (s_out() > 0) ? 1 : 0;
        end
        mism = 0; ones = 0;
        for (int i = 0; i < 127; i++) begin
            if (seq[i] != seq[i + 127]) mism++;
            ones += seq[i];
        end
        check("short_period_127", mism, 0);
        check("short_ones_per_period", ones, 64);
        mode = 0;

        // Asynchronous reset mid-run
        config_ch(15, 0, 0, 0, 0);
        trigger = 1; cyc();
        do_strobe();
        @(posedge clk);
        #3 rst_n = 0;
        #1;
        check("async_rst_sample", s_out(), 0);
        check("async_rst_active", int'(active), 0);
        @(posedge clk);
        #1 rst_n = 1;
        timer = 1; env_tick = 1; len_tick = 1; cyc();
        do_strobe();
        check("post_rst_sample", s_out(), 0);
        check("post_rst_active", int'(active), 0);

        // Randomised run against the reference model
        rst_n = 0; #2; rst_n = 1;
        model_reset();
        use_model = 1;
        for (int i = 0; i < 4000; i++) begin
            k = $urandom_range(0, 39);
            if (k == 0) begin
                trigger  = 1;
                env_init = ($urandom_range(0, 7) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
                env_dir  = 1'($urandom_range(0, 1));
                env_period = 3'($urandom_range(0, 7));
                code     = 3'($urandom_range(0, 7));
                shift    = 4'($urandom_range(0, 2));
                len_load = 6'($urandom_range(0, 63));
                len_en   = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 199) == 0) mode = ~mode;
            timer    = 1'($urandom_range(0, 1));
            env_tick = ($urandom_range(0, 9) == 0);
            len_tick = ($urandom_range(0, 19) == 0);
            strobe   = ($urandom_range(0, 2) == 0);
            cyc();
            check("rand_sample", s_out(), m_sample);
            check("rand_active", int'(active), m_active);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
